// File: rtl/ace_pkg.sv
// ACE snoop sequencer shared definitions.
//  - crresp_t : 5-bit CR response, bit positions given by the Cr* localparams
//  - acsnoop_t: AC snoop opcodes
//  - seq_state_e: sequencer FSM states
package ace_pkg;

  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;
  localparam int unsigned CrRespWidth    = 5;

  typedef logic [CrRespWidth-1:0] crresp_t;

  typedef enum logic [3:0] {
    AcReadOnce           = 4'b0000,
    AcReadShared         = 4'b0001,
    AcReadClean          = 4'b0010,
    AcReadNotSharedDirty = 4'b0011,
    AcReadUnique         = 4'b0111,
    AcCleanShared        = 4'b1000,
    AcCleanInvalid       = 4'b1001,
    AcMakeInvalid        = 4'b1101,
    AcDvmComplete        = 4'b1110,
    AcDvmMessage         = 4'b1111
  } acsnoop_t;

  typedef enum logic [1:0] {
    SeqIdle  = 2'd0,
    SeqSnoop = 2'd1,
    SeqResp  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ace_snoop_resp_merge.sv
// Combinational merge of the CR responses accepted in one cycle.
//  acc_mask_i : ports whose CR handshake happens this cycle
//  resp_i     : per-port crresp_t, port 0 in the LSBs
//  merged_o   : OR of all accepted responses
//  dt_vld_o   : some accepted response carries DataTransfer
//  dt_idx_o   : lowest accepted port index with DataTransfer
//  pd_any_o   : at least one accepted response carries PassDirty
//  pd_multi_o : two or more accepted responses carry PassDirty
module ace_snoop_resp_merge
  import ace_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic    [NumPorts-1:0] acc_mask_i,
  input  crresp_t [NumPorts-1:0] resp_i,
  output crresp_t                merged_o,
  output logic                   dt_vld_o,
  output logic    [IdxWidth-1:0] dt_idx_o,
  output logic                   pd_any_o,
  output logic                   pd_multi_o
);

  // Walk from the top index down so the last hit is the lowest index.
  always_comb begin
    merged_o   = '0;
    dt_vld_o   = 1'b0;
    dt_idx_o   = '0;
    pd_any_o   = 1'b0;
    pd_multi_o = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (acc_mask_i[i]) begin
        merged_o = merged_o | resp_i[i];
        if (resp_i[i][CrDataTransfer]) begin
          dt_vld_o = 1'b1;
          dt_idx_o = IdxWidth'(i);
        end
        if (resp_i[i][CrPassDirty]) begin
          pd_multi_o = pd_multi_o | pd_any_o;
          pd_any_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ace_snoop_sequencer.sv
// Sequences one ACE snoop at a time across NumPorts cached initiators:
// broadcasts on AC to every port except the originator, collects each CR
// response and returns one aggregated crresp_t plus the data source port.
//
// Ports:
//  clk_i, rst_ni            clock, synchronous active-low reset
//  snp_req_*                snoop request from the interconnect (valid/ready)
//  snp_resp_*               aggregated response (valid/ready), snp_data_vld_o,
//                           snp_data_src_o, snp_err_o
//  ac_valid_o/ac_ready_i    per-port AC handshake; ac_addr/snoop/prot shared
//  cr_valid_i/cr_ready_o    per-port CR handshake; cr_resp_i packed, port 0 LSBs
//
// Optional feature: define ACE_SNOOP_SEQ_TIMEOUT_EN to abort a snoop that
// has not collected every CR after TimeoutCycles cycles (snp_err_o=1).
module ace_snoop_sequencer
  import ace_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned IdxWidth      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            snp_req_valid_i,
  output logic                            snp_req_ready_o,
  input  logic [AddrWidth-1:0]            snp_addr_i,
  input  logic [3:0]                      snp_acsnoop_i,
  input  logic [2:0]                      snp_acprot_i,
  input  logic [IdxWidth-1:0]             snp_init_i,
  output logic                            snp_resp_valid_o,
  input  logic                            snp_resp_ready_i,
  output logic [CrRespWidth-1:0]          snp_resp_o,
  output logic                            snp_data_vld_o,
  output logic [IdxWidth-1:0]             snp_data_src_o,
  output logic                            snp_err_o,
  output logic [NumPorts-1:0]             ac_valid_o,
  input  logic [NumPorts-1:0]             ac_ready_i,
  output logic [AddrWidth-1:0]            ac_addr_o,
  output logic [3:0]                      ac_snoop_o,
  output logic [2:0]                      ac_prot_o,
  input  logic [NumPorts-1:0]             cr_valid_i,
  output logic [NumPorts-1:0]             cr_ready_o,
  input  logic [NumPorts*CrRespWidth-1:0] cr_resp_i
);

  seq_state_e             state_q, state_d;
  logic [NumPorts-1:0]    ac_pend_q, ac_pend_d;
  logic [NumPorts-1:0]    cr_pend_q, cr_pend_d;
  crresp_t                resp_q, resp_d;
  logic [IdxWidth-1:0]    src_q, src_d;
  logic                   err_q, err_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  acsnoop_t               snoop_q, snoop_d;
  logic [2:0]             prot_q, prot_d;

`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
  logic [CntWidth-1:0]    cnt_q, cnt_d;
`endif

  logic [NumPorts-1:0]    req_mask;
  logic [NumPorts-1:0]    cr_acc;
  crresp_t [NumPorts-1:0] cr_resp_arr;
  crresp_t                m_resp;
  logic                   m_dt_vld;
  logic [IdxWidth-1:0]    m_dt_idx;
  logic                   m_pd_any;
  logic                   m_pd_multi;
  logic                   fault;
  logic                   in_resp;

  // Every port except the originator; empty when NumPorts=1.
  assign req_mask    = ~(NumPorts'(1) << snp_init_i);
  assign cr_resp_arr = cr_resp_i;
  // CR is only taken once the port's AC handshake is behind us.
  assign cr_acc      = (state_q == SeqSnoop) ? (cr_valid_i & cr_pend_q & ~ac_pend_q) : '0;

  ace_snoop_resp_merge #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_merge (
    .acc_mask_i (cr_acc),
    .resp_i     (cr_resp_arr),
    .merged_o   (m_resp),
    .dt_vld_o   (m_dt_vld),
    .dt_idx_o   (m_dt_idx),
    .pd_any_o   (m_pd_any),
    .pd_multi_o (m_pd_multi)
  );

  always_comb begin
    state_d          = state_q;
    ac_pend_d        = ac_pend_q;
    cr_pend_d        = cr_pend_q;
    resp_d           = resp_q;
    src_d            = src_q;
    err_d            = err_q;
    addr_d           = addr_q;
    snoop_d          = snoop_q;
    prot_d           = prot_q;
    snp_req_ready_o  = 1'b0;
    snp_resp_valid_o = 1'b0;
    ac_valid_o       = '0;
    cr_ready_o       = '0;
    fault            = 1'b0;
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
    cnt_d            = cnt_q;
`endif
    unique case (state_q)
      SeqIdle: begin
        snp_req_ready_o = 1'b1;
        if (snp_req_valid_i) begin
          addr_d    = snp_addr_i;
          snoop_d   = acsnoop_t'(snp_acsnoop_i);
          prot_d    = snp_acprot_i;
          ac_pend_d = req_mask;
          cr_pend_d = req_mask;
          resp_d    = '0;
          src_d     = '0;
          err_d     = 1'b0;
          state_d   = (req_mask == '0) ? SeqResp : SeqSnoop;
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      SeqSnoop: begin
        ac_valid_o = ac_pend_q;
        cr_ready_o = cr_pend_q & ~ac_pend_q;
        ac_pend_d  = ac_pend_q & ~ac_ready_i;
        cr_pend_d  = cr_pend_q & ~cr_acc;
        resp_d     = resp_q | m_resp;
        // Responses can land out of port order; keep the lowest DT index.
        if (m_dt_vld && (!resp_q[CrDataTransfer] || (m_dt_idx < src_q))) begin
          src_d = m_dt_idx;
        end
        // Dirty ownership may only pass from one cache.
        fault = m_pd_multi | (m_pd_any & resp_q[CrPassDirty]);
        if (cr_pend_d == '0) begin
          state_d = SeqResp;
        end
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          fault     = 1'b1;
          state_d   = SeqResp;
          ac_pend_d = '0;
          cr_pend_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (fault) begin
          err_d           = 1'b1;
          resp_d[CrError] = 1'b1;
        end
      end
      SeqResp: begin
        snp_resp_valid_o = 1'b1;
        if (snp_resp_ready_i) state_d = SeqIdle;
      end
      default: state_d = SeqIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= SeqIdle;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      resp_q    <= '0;
      src_q     <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      snoop_q   <= AcReadOnce;
      prot_q    <= '0;
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      resp_q    <= resp_d;
      src_q     <= src_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Response fields read as zero outside RESP.
  assign in_resp        = (state_q == SeqResp);
  assign snp_resp_o     = in_resp ? resp_q : '0;
  assign snp_data_vld_o = in_resp & resp_q[CrDataTransfer];
  assign snp_data_src_o = in_resp ? src_q : '0;
  assign snp_err_o      = in_resp & err_q;
  assign ac_addr_o      = addr_q;
  assign ac_snoop_o     = snoop_q;
  assign ac_prot_o      = prot_q;

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Self-checking bench for ace_snoop_sequencer (NumPorts=4). A cycle-level
// model of the snooped ports tracks which AC/CR handshakes have completed
// and derives the expected AC/CR/response behaviour from them.
module tb_ace_snoop_sequencer;

  localparam int NP = 4;
  localparam int AW = 64;
  localparam int TO = 16;
  localparam int IW = 2;
`ifdef ACE_SNOOP_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          snp_req_valid_i;
  logic          snp_req_ready_o;
  logic [AW-1:0] snp_addr_i;
  logic [3:0]    snp_acsnoop_i;
  logic [2:0]    snp_acprot_i;
  logic [IW-1:0] snp_init_i;
  logic          snp_resp_valid_o;
  logic          snp_resp_ready_i;
  logic [4:0]    snp_resp_o;
  logic          snp_data_vld_o;
  logic [IW-1:0] snp_data_src_o;
  logic          snp_err_o;
  logic [NP-1:0] ac_valid_o;
  logic [NP-1:0] ac_ready_i;
  logic [AW-1:0] ac_addr_o;
  logic [3:0]    ac_snoop_o;
  logic [2:0]    ac_prot_o;
  logic [NP-1:0] cr_valid_i;
  logic [NP-1:0] cr_ready_o;
  logic [NP*5-1:0] cr_resp_i;

  int checks = 0;
  int errors = 0;

  logic [4:0] t_rsp [NP];
  int         t_acd [NP];
  int         t_crs [NP];

  always #5 clk = ~clk;

  ace_snoop_sequencer #(
    .NumPorts(NP), .AddrWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .snp_req_valid_i(snp_req_valid_i), .snp_req_ready_o(snp_req_ready_o),
    .snp_addr_i(snp_addr_i), .snp_acsnoop_i(snp_acsnoop_i),
    .snp_acprot_i(snp_acprot_i), .snp_init_i(snp_init_i),
    .snp_resp_valid_o(snp_resp_valid_o), .snp_resp_ready_i(snp_resp_ready_i),
    .snp_resp_o(snp_resp_o), .snp_data_vld_o(snp_data_vld_o),
    .snp_data_src_o(snp_data_src_o), .snp_err_o(snp_err_o),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
    .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i)
  );

  task automatic idle_inputs();
    snp_req_valid_i  = 1'b0;
    snp_resp_ready_i = 1'b0;
    ac_ready_i       = '0;
    cr_valid_i       = '0;
    cr_resp_i        = '0;
  endtask

  // One snoop transaction. Starts and ends at a sample point (#1 after posedge).
  task automatic run_txn(input int init, input logic [3:0] snp, input bit exp_done,
                         input int max_cyc, input int hold, input bit chk_lat);
    logic [NP-1:0] tgt, ac_done, cr_done, e_ac, e_cr, acr, crv;
    int acw [NP];
    logic [AW-1:0] addr;
    logic [2:0] prot;
    logic [4:0] e_resp;
    int e_src, npd, cyc;
    bit e_err, to, got;
    addr = {$urandom, $urandom};
    prot = 3'($urandom);
    tgt = 4'hF & ~(4'b0001 << init);
    ac_done = '0; cr_done = '0; to = 0; got = 0;
    for (int i = 0; i < NP; i++) acw[i] = 0;

    checks++;
    if (snp_req_ready_o !== 1'b1)
      $display("FAIL req_ready_idle got %b exp 1", snp_req_ready_o);
    snp_req_valid_i = 1'b1;
    snp_addr_i = addr; snp_acsnoop_i = snp; snp_acprot_i = prot;
    snp_init_i = IW'(init);
    @(posedge clk); #1;
    snp_req_valid_i = 1'b0;
    snp_addr_i = {$urandom, $urandom};

    for (cyc = 1; cyc <= max_cyc; cyc++) begin
      if (TO_EN && cyc == TO + 1 && (cr_done & tgt) != tgt) to = 1;
      if ((cr_done & tgt) == tgt || to) begin got = 1; break; end
      e_ac = tgt & ~ac_done;
      e_cr = tgt & ac_done & ~cr_done;
      checks++;
      if (ac_valid_o !== e_ac) begin
        errors++; $display("FAIL ac_valid cyc %0d got %b exp %b", cyc, ac_valid_o, e_ac);
      end
      checks++;
      if (cr_ready_o !== e_cr) begin
        errors++; $display("FAIL cr_ready cyc %0d got %b exp %b", cyc, cr_ready_o, e_cr);
      end
      checks++;
      if ({snp_resp_valid_o, snp_req_ready_o} !== 2'b00) begin
        errors++; $display("FAIL snoop_busy cyc %0d got resp_v/req_r %b%b exp 00",
                           cyc, snp_resp_valid_o, snp_req_ready_o);
      end
      if (e_ac != '0) begin
        checks++;
        if ({ac_addr_o, ac_snoop_o, ac_prot_o} !== {addr, snp, prot}) begin
          errors++; $display("FAIL ac_fields got %h/%h/%h exp %h/%h/%h",
                             ac_addr_o, ac_snoop_o, ac_prot_o, addr, snp, prot);
        end
      end
      for (int i = 0; i < NP; i++) begin
        acr[i] = e_ac[i] && (acw[i] >= t_acd[i]);
        crv[i] = tgt[i] ? (!cr_done[i] && cyc >= t_crs[i]) : 1'($urandom);
        cr_resp_i[i*5 +: 5] = (tgt[i] && crv[i]) ? t_rsp[i] : 5'($urandom);
      end
      ac_ready_i = acr | (4'($urandom) & ~e_ac);
      cr_valid_i = crv;
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) begin
        if (acr[i]) ac_done[i] = 1'b1;
        else if (e_ac[i]) acw[i]++;
        if (crv[i] && e_cr[i]) cr_done[i] = 1'b1;
      end
    end
    ac_ready_i = '0; cr_valid_i = '0;

    checks++;
    if (got !== exp_done) begin
      errors++; $display("FAIL completion got %b exp %b", got, exp_done);
    end
    if (!got) return;

    e_resp = '0; e_src = -1; npd = 0;
    for (int i = 0; i < NP; i++) begin
      if (tgt[i] && cr_done[i]) begin
        e_resp |= t_rsp[i];
        if (t_rsp[i][0] && e_src < 0) e_src = i;
        if (t_rsp[i][2]) npd++;
      end
    end
    e_err = (npd >= 2) || to;
    if (e_err) e_resp[1] = 1'b1;

    if (chk_lat) begin
      checks++;
      if (cyc !== 3) begin
        errors++; $display("FAIL latency got %0d exp 3", cyc);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({snp_resp_valid_o, snp_req_ready_o, ac_valid_o, cr_ready_o} !== {2'b10, 8'h00}) begin
        errors++; $display("FAIL resp_ctrl h %0d got v%b r%b ac%b cr%b exp v1 r0 ac0 cr0",
                           h, snp_resp_valid_o, snp_req_ready_o, ac_valid_o, cr_ready_o);
      end
      checks++;
      if ({snp_resp_o, snp_data_vld_o, snp_err_o} !== {e_resp, e_resp[0], e_err}) begin
        errors++; $display("FAIL resp_data h %0d got %b dv%b err%b exp %b dv%b err%b",
                           h, snp_resp_o, snp_data_vld_o, snp_err_o, e_resp, e_resp[0], e_err);
      end
      if (e_src >= 0) begin
        checks++;
        if (snp_data_src_o !== IW'(e_src)) begin
          errors++; $display("FAIL data_src got %0d exp %0d", snp_data_src_o, e_src);
        end
      end
      // A request offered alongside the response handshake must not be taken.
      snp_resp_ready_i = (h == hold);
      snp_req_valid_i  = (h == hold);
      @(posedge clk); #1;
    end
    snp_resp_ready_i = 1'b0;
    checks++;
    if ({snp_resp_valid_o, snp_req_ready_o, ac_valid_o} !== {2'b01, 4'h0}) begin
      errors++; $display("FAIL post_resp got v%b r%b ac%b exp v0 r1 ac0",
                         snp_resp_valid_o, snp_req_ready_o, ac_valid_o);
    end
    snp_req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    snp_addr_i = '1; snp_acsnoop_i = '1; snp_acprot_i = '1; snp_init_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({snp_req_ready_o, snp_resp_valid_o, ac_valid_o, cr_ready_o} !== {2'b10, 8'h00}) begin
      errors++; $display("FAIL reset_ctrl got r%b v%b ac%b cr%b exp r1 v0 ac0 cr0",
                         snp_req_ready_o, snp_resp_valid_o, ac_valid_o, cr_ready_o);
    end
    checks++;
    if ({snp_resp_o, snp_data_vld_o, snp_data_src_o, snp_err_o, ac_addr_o, ac_snoop_o, ac_prot_o} !== '0) begin
      errors++; $display("FAIL reset_data got resp %b dv%b src%0d err%b addr %h snp %h prot %h exp all 0",
                         snp_resp_o, snp_data_vld_o, snp_data_src_o, snp_err_o,
                         ac_addr_o, ac_snoop_o, ac_prot_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    t_rsp[0] = 5'b00000; t_rsp[1] = 5'b11111; t_rsp[2] = 5'b01001; t_rsp[3] = 5'b00000;
    for (int i = 0; i < NP; i++) begin t_acd[i] = 0; t_crs[i] = 1; end
    run_txn(1, 4'b0001, 1'b1, 50, 0, 1'b1);
  endtask

  task automatic test_stagger();
    t_rsp[0] = 5'b11111; t_rsp[1] = 5'b01000; t_rsp[2] = 5'b00000; t_rsp[3] = 5'b10001;
    t_acd[0] = 0; t_acd[1] = 1; t_acd[2] = 0; t_acd[3] = 5;
    t_crs[0] = 1; t_crs[1] = 2; t_crs[2] = 2; t_crs[3] = 1;
    run_txn(0, 4'($urandom), 1'b1, 50, 0, 1'b0);
  endtask

  task automatic test_dual_pd();
    t_rsp[0] = 5'b00101; t_rsp[1] = 5'b00000; t_rsp[2] = 5'b00101; t_rsp[3] = 5'b00000;
    for (int i = 0; i < NP; i++) begin t_acd[i] = 0; t_crs[i] = 1; end
    run_txn(1, 4'b0111, 1'b1, 50, 0, 1'b0);
  endtask

  task automatic test_resp_hold();
    for (int i = 0; i < NP; i++) begin
      t_rsp[i] = 5'($urandom); t_acd[i] = i % 2; t_crs[i] = 1 + i;
    end
    run_txn(3, 4'($urandom), 1'b1, 50, 10, 1'b0);
  endtask

  task automatic test_hang();
    for (int i = 0; i < NP; i++) begin
      t_rsp[i] = 5'($urandom) & 5'b11011; t_acd[i] = 0; t_crs[i] = 1;
    end
    t_crs[2] = 1000000;
    run_txn(0, 4'($urandom), TO_EN, 100, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        for (int i = 0; i < NP; i++) begin
          t_rsp[i] = 5'($urandom); t_acd[i] = 0; t_crs[i] = 1;
        end
        t_crs[2] = 1000000;
        run_txn(1, 4'($urandom), 1'b0, 4, 0, 1'b0);
      end
      idle_inputs();
      rst_ni = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      checks++;
      if ({ac_valid_o, cr_ready_o, snp_req_ready_o, snp_resp_valid_o} !== {8'h00, 2'b10}) begin
        errors++; $display("FAIL reset_mid r%0d got ac%b cr%b r%b v%b exp ac0 cr0 r1 v0",
                           r, ac_valid_o, cr_ready_o, snp_req_ready_o, snp_resp_valid_o);
      end
    end
    for (int i = 0; i < NP; i++) begin
      t_rsp[i] = 5'($urandom); t_acd[i] = 0; t_crs[i] = 1;
    end
    run_txn(2, 4'($urandom), 1'b1, 50, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NP; i++) begin
        t_rsp[i] = 5'($urandom);
        t_acd[i] = $urandom_range(0, 3);
        t_crs[i] = $urandom_range(0, 4);
      end
      run_txn($urandom_range(0, NP - 1), 4'($urandom), 1'b1, 60, $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    snp_addr_i = '0; snp_acsnoop_i = '0; snp_acprot_i = '0; snp_init_i = '0;
    test_reset();
    test_basic();
    test_stagger();
    test_dual_pd();
    test_resp_hold();
    test_random();
    test_hang();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ace_snoop_sequencer.md
Name: ace_snoop_sequencer

Overview:
- Sequences one ACE snoop transaction at a time across NumPorts cached initiators.
- Accepts a snoop request from the coherency interconnect and broadcasts it on the AC channel to every port except the originating initiator.
- Collects each CR response independently and returns one aggregated crresp_t plus the index of the port that supplies data.
- CD data routing is outside this block; it only identifies the data source port.

Parameters:
- NumPorts, 4, number of snooped initiators (>=1).
- AddrWidth, 64, snoop address width.
- TimeoutCycles, 1024, cycles in SNOOP before abort (used only with the optional feature).
- IdxWidth, $clog2(NumPorts) (min 1), derived; port index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- snp_req_valid_i  in  1  snoop request valid
- snp_req_ready_o  out  1  request accepted
- snp_addr_i  in  AddrWidth  snoop address
- snp_acsnoop_i  in  4  acsnoop_t opcode
- snp_acprot_i  in  3  protection bits
- snp_init_i  in  IdxWidth  originating port; excluded from the broadcast
- snp_resp_valid_o  out  1  aggregated response valid
- snp_resp_ready_i  in  1  response consumed
- snp_resp_o  out  5  aggregated crresp_t
- snp_data_vld_o  out  1  some port asserted DataTransfer
- snp_data_src_o  out  IdxWidth  lowest port index with DataTransfer
- snp_err_o  out  1  protocol fault (dual PassDirty or timeout)
- ac_valid_o  out  NumPorts  per-port AC valid
- ac_ready_i  in  NumPorts  per-port AC ready
- ac_addr_o  out  AddrWidth  shared AC address (registered)
- ac_snoop_o  out  4  shared AC opcode (registered)
- ac_prot_o  out  3  shared AC prot (registered)
- cr_valid_i  in  NumPorts  per-port CR valid
- cr_ready_o  out  NumPorts  per-port CR ready
- cr_resp_i  in  NumPorts*5  packed crresp_t per port, port 0 in the LSBs

Behaviour:
- Reset (synchronous, rst_ni=0 at the clock edge) sets state IDLE and clears all masks, the accumulator and the counter.
- Output values during and after reset:
  - all valid/ready outputs are 0, except snp_req_ready_o, which is 1 in IDLE;
  - snp_resp_o, snp_data_*, snp_err_o and ac_addr/snoop/prot are 0.
- Reset mid-transaction aborts immediately: AC valids drop and the transaction is lost.
- State machine:
  - IDLE: snp_req_ready_o=1. On valid&ready, register addr/snoop/prot and set ac_pend = cr_pend = all ports except snp_init_i. Clear the accumulator. Go to SNOOP. If the resulting mask is empty (NumPorts=1), go directly to RESP with a zero response.
  - SNOOP: ac_valid_o = ac_pend, held stable until the port's ac_ready_i, per AXI rules. AC handshake clears the ac_pend bit. cr_ready_o[i] = cr_pend[i] & ~ac_pend[i], so CR is accepted only in a cycle after that port's AC handshake. CR handshake clears cr_pend[i] and ORs cr_resp into the accumulator. When cr_pend==0 (including the completing cycle's update), go to RESP next cycle.
  - RESP: snp_resp_valid_o=1, outputs stable until snp_resp_ready_i; on handshake go to IDLE. No request is accepted in the same cycle as the response handshake.
- Aggregation:
  - WasUnique, IsShared, PassDirty, Error and DataTransfer are each the OR over responding ports.
  - snp_data_src_o is the lowest index whose CR had DataTransfer=1; snp_data_vld_o is the OR of DataTransfer.
  - PassDirty from two or more ports sets snp_err_o=1 and the Error bit.
- Latency: request handshake at cycle 0 → ac_valid cycle 1 → earliest CR handshake cycle 2 → snp_resp_valid_o cycle 3.
- Simultaneous CR handshakes on several ports in one cycle are all accepted and merged.

Optional Feature:
- Macro: ACE_SNOOP_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entering SNOOP and increments each SNOOP cycle.
  - At TimeoutCycles-1 with cr_pend!=0, go to RESP with snp_err_o=1 and the Error bit set. All ac_valid_o and cr_ready_o drop; this is a fault exit.
  - Counter width is $clog2(TimeoutCycles+1).
- Undefined: no counter; SNOOP waits indefinitely; snp_err_o is driven only by dual PassDirty.

Decomposition:
- ace_pkg carries crresp_t, acsnoop_t and new localparams for CR bit positions: CrDataTransfer=0, CrError=1, CrPassDirty=2, CrIsShared=3, CrWasUnique=4.
- One sub-module, ace_snoop_resp_merge, is combinational. It takes the accepted-response mask and the packed responses and produces the OR-merge, the lowest-index data source and the multiple-PassDirty detect.

Test Plan:
- NumPorts=4, init=1, acsnoop=ReadShared(0001), all ac_ready=1, CRs {p0:00000, p2:01001, p3:00000} → ac_valid 4'b1101 at cycle 1; resp=01001, data_vld=1, data_src=2, err=0.
- Staggered ac_ready (p3 ready 5 cycles late) with p3 CR valid early → cr_ready_o[3] stays 0 until the cycle after the p3 AC handshake, and ac_valid_o[3] stays stable meanwhile.
- p0 and p2 both return PassDirty+DataTransfer (00101) → snp_err_o=1, Error bit set, data_src=0.
- snp_resp_ready_i held low 10 cycles → outputs stable and snp_req_ready_o=0; after ready, the next request is accepted no earlier than the cycle after.
- With ACE_SNOOP_SEQ_TIMEOUT_EN and TimeoutCycles=16, p2 never asserts cr_valid → RESP after 16 SNOOP cycles with err=1 and Error bit set. Without the macro, still in SNOOP at cycle 100.
- rst_ni low for one cycle while in SNOOP → next cycle all ac_valid=0, snp_req_ready_o=1, and a new request completes normally.
